nvram_upload_reader: RTL

Read-side bridge serving hps_io `ioctl` upload requests from the game's save RAM (high-score/NVRAM), complementing the ROM download write path. Sits in `emu` between `hps_io` and a dual-port save RAM owned by the game core. While a matching upload session is open it pauses the core. It fetches each byte the HPS requests, stretching the transfer with `ioctl_wait`, and reports a running byte checksum and an end-of-session pulse.

---
 rtl/nvram_upload_reader.sv | 86 ++++++++
 1 files changed

// File: rtl/nvram_upload_reader.sv
// nvram_upload_reader: serves hps_io ioctl upload reads from the game's save RAM
// Ports: clk_sys/reset (sync, active-high); ioctl_upload/ioctl_index/ioctl_addr/ioctl_rd
// in from hps_io, ioctl_din/ioctl_wait back to it; ram_addr/ram_rd/ram_q to the save RAM;
// pause_req holds the core during a session; checksum is the byte sum; done pulses at end.
module nvram_upload_reader #(
    parameter int         AW           = 10,
    parameter int         SIZE         = 1024,
    parameter logic [7:0] UPLOAD_INDEX = 8'd4,
    parameter int         RAM_LAT      = 1,
    parameter logic [7:0] FILL         = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic [24:0]   ioctl_addr,
    input  logic          ioctl_rd,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_q,
    output logic          pause_req,
    output logic [7:0]    checksum,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, READY, FETCH, CAPTURE} state_t;
    localparam logic [25:0] SZ   = 26'(SIZE);
    localparam logic [1:0]  LAST = 2'(RAM_LAT - 1);
    state_t     state;
    logic [1:0] cnt;
    logic       sel;
    logic       in_range;
    logic       accept;
    assign sel      = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign in_range = {1'b0, ioctl_addr} < SZ;
    assign accept   = sel && (state == READY) && ioctl_rd;
    // wait covers the request cycle itself, so it depends combinationally on ioctl_rd
    assign ioctl_wait = (accept && in_range) || (state == FETCH) || (state == CAPTURE);
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            ioctl_din <= 8'h00;
            ram_addr  <= '0;
            ram_rd    <= 1'b0;
            pause_req <= 1'b0;
            checksum  <= 8'h00;
            done      <= 1'b0;
        end else begin
            ram_rd <= 1'b0;
            done   <= 1'b0;
            // losing sel (upload drop or index change) aborts without touching din/checksum
            if (state != IDLE && !sel) begin
                state     <= IDLE;
                pause_req <= 1'b0;
                done      <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (sel) begin
                        state     <= READY;
                        pause_req <= 1'b1;
                        checksum  <= 8'h00;
                    end
                    READY: if (ioctl_rd) begin
                        if (in_range) begin
                            ram_addr <= ioctl_addr[AW-1:0];
                            ram_rd   <= 1'b1;
                            cnt      <= 2'd0;
                            state    <= FETCH;
                        end else begin
                            ioctl_din <= FILL;
                            checksum  <= checksum + FILL;
                        end
                    end
                    FETCH: if (cnt == LAST) state <= CAPTURE; else cnt <= cnt + 2'd1;
                    CAPTURE: begin
                        ioctl_din <= ram_q;
                        checksum  <= checksum + ram_q;
                        state     <= READY;
                    end
                endcase
            end
        end
    end
endmodule
